// File: rtl/uarch_clr_sequencer.sv
// Sequencer for the fence.t microarchitectural clear: drains then clears each enabled unit in index order,
// with a per-unit drain watchdog, sticky timeout flags and a one-cycle completion pulse.
module uarch_clr_sequencer #(
    parameter int NUM_UNITS  = 4,
    parameter int CLR_CYCLES = 16,
    parameter int TIMEOUT    = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [NUM_UNITS-1:0] unit_en_i,
    input  logic [NUM_UNITS-1:0] unit_idle_i,
    output logic [NUM_UNITS-1:0] unit_clr_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [NUM_UNITS-1:0] timeout_o
);

    localparam int IW      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int CNT_MAX = (TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Lowest set bit of mask at or above 'from'; MSB of the result is the found flag.
    function automatic logic [IW:0] find_unit(input logic [NUM_UNITS-1:0] mask, input int from);
        logic [IW:0] res;
        res = {(IW + 1){1'b0}};
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if ((i >= from) && mask[i]) begin
                res = {1'b1, IW'(i)};
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [IW-1:0] sel);
        logic [NUM_UNITS-1:0] oh;
        for (int k = 0; k < NUM_UNITS; k++) begin
            oh[k] = (IW'(k) == sel);
        end
        return oh;
    endfunction

    state_t               state_r;
    logic [NUM_UNITS-1:0] en_r;
    logic [IW-1:0]        idx_r;
    logic [CW-1:0]        cnt_r;
    logic [NUM_UNITS-1:0] clr_r;
    logic                 busy_r;
    logic                 done_r;
    logic [NUM_UNITS-1:0] timeout_r;
    logic [IW:0]          first_s;
    logic [IW:0]          next_s;

    // Candidate units: first one of a new request, and the successor of the unit being cleared.
    always_comb begin
        first_s = find_unit(unit_en_i, 0);
        next_s  = find_unit(en_r, int'(idx_r) + 1);
    end

    // Sequencer FSM; outputs are registered alongside the state they decode from.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            en_r      <= {NUM_UNITS{1'b0}};
            idx_r     <= {IW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            clr_r     <= {NUM_UNITS{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= {NUM_UNITS{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    clr_r  <= {NUM_UNITS{1'b0}};
                    if (start_i) begin
                        en_r      <= unit_en_i;
                        timeout_r <= {NUM_UNITS{1'b0}};
                        cnt_r     <= {CW{1'b0}};
                        busy_r    <= 1'b1;
                        if (first_s[IW]) begin
                            state_r <= ST_DRAIN;
                            idx_r   <= first_s[IW-1:0];
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Idle takes priority over a watchdog expiring in the same cycle.
                    if (unit_idle_i[idx_r]) begin
                        state_r <= ST_CLEAR;
                        cnt_r   <= {CW{1'b0}};
                        clr_r   <= unit_onehot(idx_r);
                    end else if (cnt_r == DRAIN_LAST) begin
                        state_r          <= ST_CLEAR;
                        cnt_r            <= {CW{1'b0}};
                        clr_r            <= unit_onehot(idx_r);
                        timeout_r[idx_r] <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_CLEAR: begin
                    if (cnt_r == CLEAR_LAST) begin
                        cnt_r <= {CW{1'b0}};
                        clr_r <= {NUM_UNITS{1'b0}};
                        if (next_s[IW]) begin
                            state_r <= ST_DRAIN;
                            idx_r   <= next_s[IW-1:0];
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    clr_r   <= {NUM_UNITS{1'b0}};
                end
                default: begin
                    state_r <= ST_IDLE;
                    clr_r   <= {NUM_UNITS{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign unit_clr_o = clr_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign timeout_o  = timeout_r;

endmodule

// File: tb/tb_uarch_clr_sequencer.sv
// Scoreboard bench for uarch_clr_sequencer: a timeline model predicts each clear window and the
// completion pulse; a monitor matches what the DUT presents against those predictions.
module tb_uarch_clr_sequencer;

    localparam int NU  = 4;
    localparam int CLR = 5;
    localparam int TO  = 8;
    localparam int NEVER = 100000;

    logic          clk = 1'b0;
    logic          rst_i, start_i;
    logic [NU-1:0] unit_en_i, unit_idle_i, unit_clr_o, timeout_o;
    logic          busy_o, done_o;

    uarch_clr_sequencer #(.NUM_UNITS(NU), .CLR_CYCLES(CLR), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .unit_en_i(unit_en_i),
        .unit_idle_i(unit_idle_i), .unit_clr_o(unit_clr_o), .busy_o(busy_o),
        .done_o(done_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [NU-1:0] vec; int first; int last; } seg_t;
    typedef struct { int cyc; logic [NU-1:0] tmo; } done_t;

    seg_t  clr_q[$];
    done_t done_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    mon_en  = 1'b0;
    int    thr_rel[NU];
    int    thr_abs[NU];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Unit k reports idle from absolute cycle thr_abs[k] onward.
    task automatic drive_idle();
        for (int k = 0; k < NU; k++) unit_idle_i[k] = (cyc >= thr_abs[k]);
    endtask

    task automatic close_seg(input logic [NU-1:0] vec, input int first, input int last);
        seg_t e;
        if (clr_q.size() == 0) begin
            check("clr_unexpected", vec, 0);
        end else begin
            e = clr_q.pop_front();
            check("clr_unit", vec, e.vec);
            check("clr_first", first, e.first);
            check("clr_last", last, e.last);
        end
    endtask

    initial begin : monitor
        bit            open;
        logic [NU-1:0] ovec;
        int            ofirst;
        done_t         d;
        open = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst_i) begin
                open = 1'b0;
            end else begin
                check("clr_onehot", ($countones(unit_clr_o) <= 1), 1);
                if (open && unit_clr_o != ovec) begin
                    close_seg(ovec, ofirst, cyc - 1);
                    open = 1'b0;
                end
                if (!open && unit_clr_o != '0) begin
                    open = 1'b1; ovec = unit_clr_o; ofirst = cyc;
                end
                if (done_o) begin
                    if (done_q.size() == 0) begin
                        check("done_unexpected", 1, 0);
                    end else begin
                        d = done_q.pop_front();
                        check("done_cycle", cyc, d.cyc);
                        check("done_timeout", timeout_o, d.tmo);
                    end
                end
            end
        end
    end

    // Timeline model: each enabled unit drains until idle (or TO cycles), then clears for CLR cycles.
    task automatic run_trial(input logic [NU-1:0] en, input bit dup);
        int            s, t, c, len, done_rel;
        logic [NU-1:0] tmo;
        logic [NU-1:0] one;
        seg_t          e;
        done_t         d;
        @(negedge clk);
        s = cyc; t = 1; tmo = '0; one = 4'b0001;
        for (int k = 0; k < NU; k++) thr_abs[k] = s + thr_rel[k];
        for (int k = 0; k < NU; k++) begin
            if (en[k]) begin
                c = (thr_rel[k] > t) ? thr_rel[k] : t;
                if (c <= t + TO - 1) begin
                    len = c - t + 1;
                end else begin
                    len = TO;
                    tmo[k] = 1'b1;
                end
                e.vec = one << k; e.first = s + t + len; e.last = e.first + CLR - 1;
                clr_q.push_back(e);
                t = t + len + CLR;
            end
        end
        done_rel = t;
        d.cyc = s + done_rel; d.tmo = tmo;
        done_q.push_back(d);
        start_i = 1'b1; unit_en_i = en; drive_idle();
        for (int i = 1; i <= done_rel + 1; i++) begin
            @(negedge clk);
            start_i   = (i <= done_rel) && ((dup && i == 1) || ($urandom_range(0, 3) == 0));
            unit_en_i = 4'($urandom);
            drive_idle();
            check("busy", busy_o, (i <= done_rel));
        end
        check("timeout_hold", timeout_o, tmo);
        start_i = 1'b0;
    endtask

    task automatic run_reset_trial();
        int s;
        mon_en = 1'b0;
        thr_rel[0] = NEVER;
        for (int k = 1; k < NU; k++) thr_rel[k] = 0;
        @(negedge clk);
        s = cyc;
        for (int k = 0; k < NU; k++) thr_abs[k] = s + thr_rel[k];
        start_i = 1'b1; unit_en_i = 4'b1111; drive_idle();
        while (cyc < s + 16) begin
            @(negedge clk);
            start_i = 1'b0; drive_idle();
        end
        check("pre_rst_clr", unit_clr_o, 4'b0010);
        check("pre_rst_timeout", timeout_o, 4'b0001);
        rst_i = 1'b1;
        @(negedge clk);
        check("rst_clr", unit_clr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_done", done_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    initial begin : stimulus
        rst_i = 1'b1; start_i = 1'b0; unit_en_i = '0; unit_idle_i = '0;
        for (int k = 0; k < NU; k++) begin thr_rel[k] = 0; thr_abs[k] = 0; end
        repeat (3) @(negedge clk);
        check("reset_clr", unit_clr_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_timeout", timeout_o, 0);
        rst_i = 1'b0;
        mon_en = 1'b1;

        run_trial(4'b1111, 1'b0);
        run_trial(4'b0101, 1'b0);
        thr_rel[0] = NEVER;
        run_trial(4'b0001, 1'b0);
        thr_rel[0] = TO;
        run_trial(4'b0001, 1'b0);
        run_trial(4'b0000, 1'b1);

        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < NU; k++)
                thr_rel[k] = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 40));
            run_trial(4'($urandom), 1'($urandom_range(0, 1)));
        end

        run_reset_trial();
        for (int k = 0; k < NU; k++) thr_rel[k] = 0;
        run_trial(4'b1110, 1'b0);

        repeat (3) @(negedge clk);
        check("clr_q_empty", clr_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
